// File: rtl/commit_trace_buffer.sv
// Retirement trace for the 5-stage CPU: shadow tags follow the pipeline and each writeback
// pushes one record into a FWFT FIFO. Define TRACE_WDATA_EN to store RegWriteData per entry.
module commit_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int ID_W  = 8,
  parameter int CYC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                PC_inst,
  input  logic [15:0]                fetch_instr,
  input  logic                       IF_ID_stall,
  input  logic                       IF_flush,
  input  logic                       ID_flush,
  input  logic                       MEM_WB_RegWrite,
  input  logic [3:0]                 MEM_WB_reg_rd,
  input  logic [15:0]                RegWriteData,
  input  logic                       hlt,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [ID_W-1:0]            rec_id,
  output logic [15:0]                rec_pc,
  output logic [15:0]                rec_instr,
  output logic [CYC_W-1:0]           rec_fetch_cyc,
  output logic [CYC_W-1:0]           rec_wb_cyc,
  output logic                       rec_wen,
  output logic [3:0]                 rec_rd,
  output logic [15:0]                rec_wdata,
  output logic                       rec_hlt,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [15:0]      pc;
    logic [15:0]      instr;
    logic [CYC_W-1:0] fetch_cyc;
  } tag_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [15:0]      pc;
    logic [15:0]      instr;
    logic [CYC_W-1:0] fetch_cyc;
    logic [CYC_W-1:0] wb_cyc;
    logic             wen;
    logic [3:0]       rd;
`ifdef TRACE_WDATA_EN
    logic [15:0]      wdata;
`endif
    logic             hlt;
  } entry_t;

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [ID_W-1:0]  next_id_q, next_id_d;
  tag_t             if_id_q, if_id_d;
  tag_t             id_ex_q, id_ex_d;
  tag_t             ex_mem_q, ex_mem_d;
  tag_t             mem_wb_q, mem_wb_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  logic             pop, push, retire, full;
  entry_t           new_entry;
  entry_t           head;

  always_comb begin
    cyc_d = cyc_q + CYC_W'(1);

    pop    = rec_valid && rec_ready;
    full   = (count_q == CNT_W'(DEPTH));
    retire = mem_wb_q.valid && !done_q;
    push   = retire && (!full || pop);

    new_entry           = '0;
    new_entry.id        = mem_wb_q.id;
    new_entry.pc        = mem_wb_q.pc;
    new_entry.instr     = mem_wb_q.instr;
    new_entry.fetch_cyc = mem_wb_q.fetch_cyc;
    new_entry.wb_cyc    = cyc_q;
    new_entry.wen       = MEM_WB_RegWrite;
    new_entry.rd        = MEM_WB_reg_rd;
`ifdef TRACE_WDATA_EN
    new_entry.wdata     = RegWriteData;
`endif
    new_entry.hlt       = hlt;

    // A flushed or stalled fetch is never counted, so sequence IDs stay gap-free
    if_id_d   = if_id_q;
    next_id_d = next_id_q;
    if (IF_flush) begin
      if_id_d.valid = 1'b0;
    end else if (!IF_ID_stall) begin
      if_id_d.valid     = 1'b1;
      if_id_d.id        = next_id_q;
      if_id_d.pc        = PC_inst;
      if_id_d.instr     = fetch_instr;
      if_id_d.fetch_cyc = cyc_q;
      next_id_d         = next_id_q + ID_W'(1);
    end

    id_ex_d = if_id_q;
    if (ID_flush || IF_ID_stall) id_ex_d.valid = 1'b0;
    ex_mem_d = id_ex_q;
    mem_wb_d = ex_mem_q;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    overflow_d = overflow_q | (retire && !push);
    done_d     = done_q | (retire && hlt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= '0;
      next_id_q  <= '0;
      if_id_q    <= '0;
      id_ex_q    <= '0;
      ex_mem_q   <= '0;
      mem_wb_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      next_id_q  <= next_id_d;
      if_id_q    <= if_id_d;
      id_ex_q    <= id_ex_d;
      ex_mem_q   <= ex_mem_d;
      mem_wb_q   <= mem_wb_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is live
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign rec_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign done      = done_q;

  always_comb begin
    rec_id        = '0;
    rec_pc        = '0;
    rec_instr     = '0;
    rec_fetch_cyc = '0;
    rec_wb_cyc    = '0;
    rec_wen       = 1'b0;
    rec_rd        = '0;
    rec_hlt       = 1'b0;
    if (rec_valid) begin
      rec_id        = head.id;
      rec_pc        = head.pc;
      rec_instr     = head.instr;
      rec_fetch_cyc = head.fetch_cyc;
      rec_wb_cyc    = head.wb_cyc;
      rec_wen       = head.wen;
      rec_rd        = head.rd;
      rec_hlt       = head.hlt;
    end
  end

`ifdef TRACE_WDATA_EN
  assign rec_wdata = rec_valid ? head.wdata : 16'h0000;
`else
  logic unused_wdata;
  assign unused_wdata = ^RegWriteData;
  assign rec_wdata    = 16'h0000;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: a pipeline/FIFO scoreboard checked every
// cycle, plus scenario tasks that check drained records against fixed expectations.
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int ID_W  = 8;
  localparam int CYC_W = 16;

  logic        clk;
  logic        rst;
  logic [15:0] PC_inst;
  logic [15:0] fetch_instr;
  logic        IF_ID_stall;
  logic        IF_flush;
  logic        ID_flush;
  logic        MEM_WB_RegWrite;
  logic [3:0]  MEM_WB_reg_rd;
  logic [15:0] RegWriteData;
  logic        hlt;
  logic        rec_valid;
  logic        rec_ready;
  logic [7:0]  rec_id;
  logic [15:0] rec_pc;
  logic [15:0] rec_instr;
  logic [15:0] rec_fetch_cyc;
  logic [15:0] rec_wb_cyc;
  logic        rec_wen;
  logic [3:0]  rec_rd;
  logic [15:0] rec_wdata;
  logic        rec_hlt;
  logic [3:0]  count;
  logic        overflow;
  logic        done;

  commit_trace_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .PC_inst(PC_inst), .fetch_instr(fetch_instr),
    .IF_ID_stall(IF_ID_stall), .IF_flush(IF_flush), .ID_flush(ID_flush),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_reg_rd(MEM_WB_reg_rd),
    .RegWriteData(RegWriteData), .hlt(hlt), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_id(rec_id), .rec_pc(rec_pc), .rec_instr(rec_instr), .rec_fetch_cyc(rec_fetch_cyc),
    .rec_wb_cyc(rec_wb_cyc), .rec_wen(rec_wen), .rec_rd(rec_rd), .rec_wdata(rec_wdata),
    .rec_hlt(rec_hlt), .count(count), .overflow(overflow), .done(done)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] fc;
    logic [15:0] wc;
    logic        wen;
    logic [3:0]  rd;
    logic [15:0] wdata;
    logic        hlt;
  } rec_t;

  typedef struct packed {
    logic        v;
    logic [7:0]  id;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] fc;
  } mtag_t;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs set by the scenario tasks
  logic        d_rst = 1'b1, d_stall = 1'b0, d_iflush = 1'b0, d_idflush = 1'b0;
  logic        d_ready = 1'b0, d_hlt = 1'b0;
  logic [15:0] d_pc = 16'h0, d_instr = 16'h0;

  // Reference model state
  logic        m_known = 1'b0;
  logic [15:0] m_cyc = 16'h0;
  logic [7:0]  m_nid = 8'h0;
  mtag_t       m_ifid = '0, m_idex = '0, m_exmem = '0, m_memwb = '0;
  logic        m_done = 1'b0, m_ovf = 1'b0;
  rec_t        m_q[$];
  rec_t        drained[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic rec_t dut_rec();
    rec_t r;
    r = '{rec_id, rec_pc, rec_instr, rec_fetch_cyc, rec_wb_cyc, rec_wen, rec_rd, rec_wdata, rec_hlt};
    return r;
  endfunction

  // One clock: check outputs against the model, drive inputs, advance the model
  task automatic step();
    logic        pop, wen;
    logic [3:0]  rd;
    logic [15:0] wd;
    rec_t        r;
    @(negedge clk);
    if (m_known) begin
      checks++;
      if (rec_valid !== (m_q.size() != 0)) begin
        errors++; $display("[TB] FAIL sb_valid got %0b exp %0b", rec_valid, m_q.size() != 0);
      end
      checks++;
      if (count !== 4'(m_q.size())) begin
        errors++; $display("[TB] FAIL sb_count got %0d exp %0d", count, m_q.size());
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++; $display("[TB] FAIL sb_overflow got %0b exp %0b", overflow, m_ovf);
      end
      checks++;
      if (done !== m_done) begin
        errors++; $display("[TB] FAIL sb_done got %0b exp %0b", done, m_done);
      end
      if (m_q.size() != 0) begin
        checks++;
        if (dut_rec() !== m_q[0]) begin
          errors++; $display("[TB] FAIL sb_head got %h exp %h", dut_rec(), m_q[0]);
        end
      end
    end
    wen = m_cyc[0];
    rd  = m_cyc[3:0] ^ 4'h5;
    wd  = m_cyc ^ 16'hA5C3;
    rst = d_rst; PC_inst = d_pc; fetch_instr = d_instr; IF_ID_stall = d_stall;
    IF_flush = d_iflush; ID_flush = d_idflush; MEM_WB_RegWrite = wen;
    MEM_WB_reg_rd = rd; RegWriteData = wd; hlt = d_hlt; rec_ready = d_ready;
    if (!d_rst && d_ready && rec_valid) drained.push_back(dut_rec());
    pop = d_ready && (m_q.size() != 0) && !d_rst;
    @(posedge clk);
    if (d_rst) begin
      m_cyc = 16'h0; m_nid = 8'h0; m_ifid = '0; m_idex = '0; m_exmem = '0; m_memwb = '0;
      m_done = 1'b0; m_ovf = 1'b0; m_q.delete(); m_known = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_memwb.v && !m_done) begin
`ifdef TRACE_WDATA_EN
        r = '{m_memwb.id, m_memwb.pc, m_memwb.instr, m_memwb.fc, m_cyc, wen, rd, wd, d_hlt};
`else
        r = '{m_memwb.id, m_memwb.pc, m_memwb.instr, m_memwb.fc, m_cyc, wen, rd, 16'h0, d_hlt};
`endif
        if (m_q.size() < DEPTH) m_q.push_back(r);
        else m_ovf = 1'b1;
        if (d_hlt) m_done = 1'b1;
      end
      m_memwb = m_exmem;
      m_exmem = m_idex;
      m_idex  = (d_idflush || d_stall) ? '0 : m_ifid;
      if (d_iflush) m_ifid.v = 1'b0;
      else if (!d_stall) begin
        m_ifid = '{1'b1, m_nid, d_pc, d_instr, m_cyc};
        m_nid  = m_nid + 8'd1;
      end
      m_cyc = m_cyc + 16'd1;
    end
  endtask

  task automatic do_reset();
    d_rst = 1'b1; d_stall = 1'b0; d_iflush = 1'b0; d_idflush = 1'b0; d_ready = 1'b0; d_hlt = 1'b0;
    step();
    d_rst = 1'b0; d_iflush = 1'b1;
    step();
    d_iflush = 1'b0;
    drained.delete();
  endtask

  task automatic drain_pipe(input int n);
    d_iflush = 1'b1; d_stall = 1'b0; d_idflush = 1'b0;
    repeat (n) step();
    d_iflush = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({rec_valid, count, overflow, done} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_flags got %b exp 0", {rec_valid, count, overflow, done});
    end
    checks++;
    if (dut_rec() !== '0) begin
      errors++; $display("[TB] FAIL reset_fields got %h exp 0", dut_rec());
    end
  endtask

  task automatic test_straight();
    do_reset();
    d_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d_pc = 16'(2 * i); d_instr = 16'h1000 | d_pc;
      step();
    end
    drain_pipe(8);
    checks++;
    if (drained.size() != 20) begin
      errors++; $display("[TB] FAIL straight_count got %0d exp 20", drained.size());
    end else begin
      checks++;
      if ({drained[0].id, drained[0].pc, drained[0].fc, drained[0].wc} !== {8'd0, 16'h0, 16'd1, 16'd5}) begin
        errors++; $display("[TB] FAIL straight_first got id=%0d pc=%h fc=%0d wc=%0d exp 0/0000/1/5",
                           drained[0].id, drained[0].pc, drained[0].fc, drained[0].wc);
      end
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (drained[i].id !== 8'(i) || drained[i].pc !== 16'(2 * i) ||
            (drained[i].wc - drained[i].fc) !== 16'd4) begin
          errors++; $display("[TB] FAIL straight_rec%0d got id=%0d pc=%h span=%0d exp id=%0d pc=%h span=4",
                             i, drained[i].id, drained[i].pc, drained[i].wc - drained[i].fc, i, 16'(2 * i));
        end
      end
    end
  endtask

  task automatic test_load_use();
    logic stalled = 1'b0;
    do_reset();
    d_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      d_stall = m_ifid.v && (m_ifid.id == 8'd3) && !stalled;
      if (d_stall) stalled = 1'b1;
      d_pc = 16'(2 * m_nid); d_instr = 16'h2000 | d_pc;
      step();
    end
    drain_pipe(8);
    checks++;
    if (drained.size() != 13) begin
      errors++; $display("[TB] FAIL loaduse_count got %0d exp 13", drained.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        checks++;
        if (drained[i].id !== 8'(i) || (drained[i].wc - drained[i].fc) !== ((i == 3) ? 16'd5 : 16'd4)) begin
          errors++; $display("[TB] FAIL loaduse_rec%0d got id=%0d span=%0d exp id=%0d span=%0d",
                             i, drained[i].id, drained[i].wc - drained[i].fc, i, (i == 3) ? 5 : 4);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic taken = 1'b0;
    do_reset();
    d_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      d_iflush = (m_nid == 8'd5) && !taken;
      if (d_iflush) begin
        taken = 1'b1; d_pc = 16'hBAD0;
      end else begin
        d_pc = (m_nid < 8'd5) ? 16'(2 * m_nid) : 16'(16'h0200 + 2 * (m_nid - 8'd5));
      end
      d_instr = 16'h3000 | d_pc;
      step();
    end
    drain_pipe(8);
    checks++;
    if (drained.size() != 13) begin
      errors++; $display("[TB] FAIL branch_count got %0d exp 13", drained.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        checks++;
        if (drained[i].id !== 8'(i) || drained[i].pc === 16'hBAD0 ||
            drained[i].pc !== ((i < 5) ? 16'(2 * i) : 16'(16'h0200 + 2 * (i - 5)))) begin
          errors++; $display("[TB] FAIL branch_rec%0d got id=%0d pc=%h", i, drained[i].id, drained[i].pc);
        end
      end
    end
  endtask

  task automatic test_id_flush();
    do_reset();
    d_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_idflush = m_ifid.v && (m_ifid.id == 8'd2);
      d_pc = 16'(2 * m_nid); d_instr = 16'h4000 | d_pc;
      step();
    end
    drain_pipe(8);
    checks++;
    if (drained.size() != 5) begin
      errors++; $display("[TB] FAIL idflush_count got %0d exp 5", drained.size());
    end else begin
      checks++;
      if ({drained[1].id, drained[2].id} !== {8'd1, 8'd3}) begin
        errors++; $display("[TB] FAIL idflush_ids got %0d,%0d exp 1,3", drained[1].id, drained[2].id);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d_pc = 16'(2 * i); d_instr = 16'h5000 | d_pc;
      step();
    end
    drain_pipe(6);
    #1;
    checks++;
    if ({count, overflow} !== {4'd8, 1'b1}) begin
      errors++; $display("[TB] FAIL overflow_state got count=%0d ovf=%0b exp 8/1", count, overflow);
    end
    d_ready = 1'b1;
    drain_pipe(12);
    checks++;
    if (drained.size() != DEPTH) begin
      errors++; $display("[TB] FAIL overflow_drain got %0d exp %0d", drained.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (drained[i].id !== 8'(i)) begin
          errors++; $display("[TB] FAIL overflow_rec%0d got id=%0d exp %0d", i, drained[i].id, i);
        end
      end
    end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d_pc = 16'(2 * i); d_instr = 16'h6000 | d_pc;
      step();
    end
    d_iflush = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_ready = (m_cyc == 16'd13);
      step();
    end
    d_ready = 1'b0;
    #1;
    checks++;
    if ({count, overflow, rec_id} !== {4'd8, 1'b0, 8'd1}) begin
      errors++; $display("[TB] FAIL fullpop_state got count=%0d ovf=%0b head=%0d exp 8/0/1",
                         count, overflow, rec_id);
    end
    d_ready = 1'b1;
    drain_pipe(12);
    checks++;
    if (drained.size() != 9) begin
      errors++; $display("[TB] FAIL fullpop_drain got %0d exp 9", drained.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (drained[i].id !== 8'(i)) begin
          errors++; $display("[TB] FAIL fullpop_rec%0d got id=%0d exp %0d", i, drained[i].id, i);
        end
      end
    end
  endtask

  task automatic test_hlt();
    do_reset();
    d_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d_hlt = m_memwb.v && (m_memwb.id == 8'd9);
      d_pc = 16'(2 * i); d_instr = 16'h7000 | d_pc;
      step();
    end
    d_ready = 1'b0; d_iflush = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_hlt = m_memwb.v && (m_memwb.id == 8'd9);
      step();
    end
    d_hlt = 1'b0;
    #1;
    checks++;
    if ({done, count, overflow} !== {1'b1, 4'd3, 1'b0}) begin
      errors++; $display("[TB] FAIL hlt_state got done=%0b count=%0d ovf=%0b exp 1/3/0", done, count, overflow);
    end
    drained.delete();
    d_ready = 1'b1;
    repeat (2) step();
    d_ready = 1'b0;
    #1;
    checks++;
    if ({rec_valid, rec_id, rec_hlt} !== {1'b1, 8'd9, 1'b1}) begin
      errors++; $display("[TB] FAIL hlt_head got v=%0b id=%0d hlt=%0b exp 1/9/1", rec_valid, rec_id, rec_hlt);
    end
    checks++;
    if (drained.size() != 2 || {drained[0].id, drained[0].hlt, drained[1].id, drained[1].hlt} !== {8'd7, 1'b0, 8'd8, 1'b0}) begin
      errors++; $display("[TB] FAIL hlt_pre got n=%0d exp ids 7,8 without hlt", drained.size());
    end
    repeat (4) step();
    #1;
    checks++;
    if (count !== 4'd1) begin
      errors++; $display("[TB] FAIL hlt_nopush got count=%0d exp 1", count);
    end
    d_rst = 1'b1;
    step();
    d_rst = 1'b0; d_iflush = 1'b0;
    #1;
    checks++;
    if ({rec_valid, count, done} !== {1'b0, 4'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL midreset got v=%0b count=%0d done=%0b exp 0/0/0", rec_valid, count, done);
    end
  endtask

  initial begin
    rst = 1'b1; PC_inst = 16'h0; fetch_instr = 16'h0; IF_ID_stall = 1'b0; IF_flush = 1'b0;
    ID_flush = 1'b0; MEM_WB_RegWrite = 1'b0; MEM_WB_reg_rd = 4'h0; RegWriteData = 16'h0;
    hlt = 1'b0; rec_ready = 1'b0;
    $display("[TB] start");
    test_reset();
    test_straight();
    test_load_use();
    test_branch();
    test_id_flush();
    test_overflow();
    test_full_pop_push();
    test_hlt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
